// File: rtl/lane_lsu_ctrl.sv
// Per-lane SIMD load/store controller: one op per handshake, a single memory-access cycle,
// and a registered per-lane response. The shader configuration package lives at the top of this file.
package GPU_Shader_pkg;
    localparam int lanes     = 4;
    localparam int MEM_DEPTH = 32;
    typedef logic [31:0] word_t;
endpackage

module lane_lsu_ctrl
    import GPU_Shader_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_op,
    input  logic [lanes-1:0]                 req_mask,
    input  logic [lanes-1:0][ADDR_WIDTH-1:0] req_addr,
    input  word_t [lanes-1:0]                req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output word_t [lanes-1:0]                rsp_data_a,
    output word_t [lanes-1:0]                rsp_data_b,
    output logic [lanes-1:0]                 rsp_err,
    output logic [lanes-1:0]                 mem_write_en,
    output logic [lanes-1:0][ADDR_WIDTH-1:0] mem_write_addr,
    output word_t [lanes-1:0]                mem_write_data,
    output logic [lanes-1:0][ADDR_WIDTH-1:0] mem_read_addr_a,
    input  word_t [lanes-1:0]                mem_read_data_a,
    output logic [lanes-1:0][ADDR_WIDTH-1:0] mem_read_addr_b,
    input  word_t [lanes-1:0]                mem_read_data_b,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             ops_done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PAIR  = 2'b10;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [1:0]                       state_r;
    logic [1:0]                       state_nxt_s;
    logic [1:0]                       op_r;
    logic [lanes-1:0]                 mask_r;
    logic [lanes-1:0]                 valid_r;
    logic [lanes-1:0][ADDR_WIDTH-1:0] addr_r;
    logic [lanes-1:0][ADDR_WIDTH-1:0] addr_b_r;
    word_t [lanes-1:0]                wdata_r;
    word_t [lanes-1:0]                rsp_a_r;
    word_t [lanes-1:0]                rsp_b_r;
    logic [lanes-1:0]                 rsp_err_r;
    logic [CNT_WIDTH-1:0]             ops_r;

    logic                             accept_s;
    logic                             rsp_hs_s;
    logic [lanes-1:0]                 req_v_s;
    logic [lanes-1:0][ADDR_WIDTH-1:0] req_addr_b_s;
    word_t [lanes-1:0]                rsp_a_nxt_s;
    word_t [lanes-1:0]                rsp_b_nxt_s;
    logic [lanes-1:0]                 rsp_err_nxt_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign rsp_hs_s = rsp_ready && (state_r == ST_RESP);

    // Lane validity of the incoming request; range checks use one extra bit so addr+1 never wraps.
    always_comb begin
        req_v_s      = '0;
        req_addr_b_s = '0;
        for (int i = 0; i < lanes; i++) begin
            logic [ADDR_WIDTH:0] ext_a;
            logic [ADDR_WIDTH:0] ext_b;
            ext_a           = {1'b0, req_addr[i]};
            ext_b           = ext_a + {{ADDR_WIDTH{1'b0}}, 1'b1};
            req_addr_b_s[i] = ext_b[ADDR_WIDTH-1:0];
            case (req_op)
                OP_LOAD, OP_STORE: req_v_s[i] = req_mask[i] && (ext_a < DEPTH_L);
                OP_PAIR:           req_v_s[i] = req_mask[i] && (ext_a < DEPTH_L) && (ext_b < DEPTH_L);
                default:           req_v_s[i] = 1'b0;
            endcase
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture; these registers alone feed the memory ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 2'b00;
            mask_r   <= '0;
            valid_r  <= '0;
            addr_r   <= '0;
            addr_b_r <= '0;
            wdata_r  <= '0;
        end else if (accept_s) begin
            op_r     <= req_op;
            mask_r   <= req_mask;
            valid_r  <= req_v_s;
            addr_r   <= req_addr;
            addr_b_r <= req_addr_b_s;
            wdata_r  <= req_wdata;
        end
    end

    // Response data sampled from the read ports at the end of EXEC, otherwise held.
    always_comb begin
        rsp_a_nxt_s   = rsp_a_r;
        rsp_b_nxt_s   = rsp_b_r;
        rsp_err_nxt_s = rsp_err_r;
        if (state_r == ST_EXEC) begin
            for (int i = 0; i < lanes; i++) begin
                if (valid_r[i] && ((op_r == OP_LOAD) || (op_r == OP_PAIR))) begin
                    rsp_a_nxt_s[i] = mem_read_data_a[i];
                end else begin
                    rsp_a_nxt_s[i] = '0;
                end
                if (valid_r[i] && (op_r == OP_PAIR)) begin
                    rsp_b_nxt_s[i] = mem_read_data_b[i];
                end else begin
                    rsp_b_nxt_s[i] = '0;
                end
            end
            rsp_err_nxt_s = mask_r & ~valid_r;
        end else begin
            rsp_a_nxt_s   = rsp_a_r;
            rsp_b_nxt_s   = rsp_b_r;
            rsp_err_nxt_s = rsp_err_r;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_a_r   <= '0;
            rsp_b_r   <= '0;
            rsp_err_r <= '0;
        end else begin
            rsp_a_r   <= rsp_a_nxt_s;
            rsp_b_r   <= rsp_b_nxt_s;
            rsp_err_r <= rsp_err_nxt_s;
        end
    end

    // Completed-op counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_r <= '0;
        end else if (rsp_hs_s && (ops_r != {CNT_WIDTH{1'b1}})) begin
            ops_r <= ops_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Write enable is live only during EXEC, so an async reset there cancels the commit.
    assign mem_write_en    = ((state_r == ST_EXEC) && (op_r == OP_STORE)) ? valid_r : '0;
    assign mem_write_addr  = addr_r;
    assign mem_write_data  = wdata_r;
    assign mem_read_addr_a = addr_r;
    assign mem_read_addr_b = addr_b_r;

    assign req_ready  = (state_r == ST_IDLE);
    assign rsp_valid  = (state_r == ST_RESP);
    assign busy       = (state_r != ST_IDLE);
    assign rsp_data_a = rsp_a_r;
    assign rsp_data_b = rsp_b_r;
    assign rsp_err    = rsp_err_r;
    assign ops_done   = ops_r;

endmodule

// File: tb/tb_lane_lsu_ctrl.sv
// Directed bench for lane_lsu_ctrl with a 4-lane, 32-word behavioural lane memory.
module tb_lane_lsu_ctrl;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [3:0]        req_mask;
    logic [3:0][5:0]   req_addr;
    logic [3:0][31:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0][31:0]  rsp_data_a;
    logic [3:0][31:0]  rsp_data_b;
    logic [3:0]        rsp_err;
    logic [3:0]        mem_write_en;
    logic [3:0][5:0]   mem_write_addr;
    logic [3:0][31:0]  mem_write_data;
    logic [3:0][5:0]   mem_read_addr_a;
    logic [3:0][31:0]  mem_read_data_a;
    logic [3:0][5:0]   mem_read_addr_b;
    logic [3:0][31:0]  mem_read_data_b;
    logic              busy;
    logic [15:0]       ops_done;

    logic [31:0] mem [0:31];
    int total = 0;
    int bad   = 0;

    lane_lsu_ctrl #(.ADDR_WIDTH(6), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_read_addr_a(mem_read_addr_a), .mem_read_data_a(mem_read_data_a),
        .mem_read_addr_b(mem_read_addr_b), .mem_read_data_b(mem_read_data_b),
        .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_write_en[i] && (mem_write_addr[i] < 6'd32)) mem[mem_write_addr[i][4:0]] <= mem_write_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_read_data_a[i] = (mem_read_addr_a[i] < 6'd32) ? mem[mem_read_addr_a[i][4:0]] : 32'd0;
            mem_read_data_b[i] = (mem_read_addr_b[i] < 6'd32) ? mem[mem_read_addr_b[i][4:0]] : 32'd0;
        end
    end

    // Issue one op, wait (bounded) for the response, capture it, then complete the handshake.
    task automatic run_op(input logic [1:0] op, input logic [3:0] mask, input logic [3:0][5:0] addr,
                          input logic [3:0][31:0] wd, output logic [3:0][31:0] ra,
                          output logic [3:0][31:0] rb, output logic [3:0] err,
                          output logic [3:0] wen_or, output int wen_cyc, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_mask = mask; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wen_or  = mem_write_en;
        wen_cyc = (mem_write_en != 4'd0) ? 1 : 0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (mem_write_en != 4'd0) wen_cyc++;
            wen_or |= mem_write_en;
        end
        if (mem_write_en != 4'd0) wen_cyc++;
        ra = rsp_data_a; rb = rsp_data_b; err = rsp_err;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'($urandom); req_op = 2'($urandom); req_mask = 4'($urandom);
        req_addr = 24'($urandom); req_wdata = {$urandom, $urandom, $urandom, $urandom};
        rsp_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%b%b exp=00", rsp_valid, busy); end
        total++; if (rsp_data_a !== 128'd0 || rsp_data_b !== 128'd0 || rsp_err !== 4'd0) begin bad++; $display("FAIL reset_rsp got=%h %h %b exp=0", rsp_data_a, rsp_data_b, rsp_err); end
        total++; if (mem_write_en !== 4'd0 || mem_write_addr !== 24'd0 || mem_write_data !== 128'd0) begin bad++; $display("FAIL reset_wr got=%b %h %h exp=0", mem_write_en, mem_write_addr, mem_write_data); end
        total++; if (mem_read_addr_a !== 24'd0 || mem_read_addr_b !== 24'd0) begin bad++; $display("FAIL reset_rd_addr got=%h %h exp=0", mem_read_addr_a, mem_read_addr_b); end
        total++; if (ops_done !== 16'd0) begin bad++; $display("FAIL reset_ops got=%0d exp=0", ops_done); end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [3:0][31:0] ra, rb; logic [3:0] err, wen; int wc, lat;
        logic [3:0][31:0] wd;
        wd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        run_op(2'b01, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, wd, ra, rb, err, wen, wc, lat);
        total++; if (wen !== 4'b1111 || wc !== 1) begin bad++; $display("FAIL store_wen got=%b cycles=%0d exp=1111 cycles=1", wen, wc); end
        total++; if (lat !== 1) begin bad++; $display("FAIL store_latency got=%0d exp=1", lat); end
        total++; if (ra !== 128'd0 || rb !== 128'd0 || err !== 4'd0) begin bad++; $display("FAIL store_rsp got=%h %h %b exp=0", ra, rb, err); end
        run_op(2'b00, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 128'd0, ra, rb, err, wen, wc, lat);
        total++; if (ra !== wd || rb !== 128'd0 || err !== 4'd0) begin bad++; $display("FAIL load_rsp got=%h %h %b exp=%h 0 0", ra, rb, err, wd); end
        total++; if (wc !== 0) begin bad++; $display("FAIL load_nowrite got=%0d exp=0", wc); end
        total++; if (ops_done !== 16'd2) begin bad++; $display("FAIL store_load_ops got=%0d exp=2", ops_done); end
    endtask

    task automatic test_load_pair();
        logic [3:0][31:0] ra, rb; logic [3:0] err, wen; int wc, lat;
        run_op(2'b10, 4'b1111, {6'd32, 6'd31, 6'd4, 6'd0}, 128'd0, ra, rb, err, wen, wc, lat);
        total++; if (ra !== {32'd0, 32'd0, 32'h0000_1004, 32'hAAAA_0000}) begin bad++; $display("FAIL pair_data_a got=%h", ra); end
        total++; if (rb !== {32'd0, 32'd0, 32'h0000_1005, 32'hBBBB_0001}) begin bad++; $display("FAIL pair_data_b got=%h", rb); end
        total++; if (err !== 4'b1100) begin bad++; $display("FAIL pair_err got=%b exp=1100", err); end
    endtask

    task automatic test_oob_store();
        logic [3:0][31:0] ra, rb; logic [3:0] err, wen; int wc, lat;
        run_op(2'b01, 4'b0101, {6'd12, 6'd10, 6'd11, 6'd40},
               {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0040}, ra, rb, err, wen, wc, lat);
        total++; if (wen !== 4'b0100) begin bad++; $display("FAIL oob_wen got=%b exp=0100", wen); end
        total++; if (err !== 4'b0001) begin bad++; $display("FAIL oob_err got=%b exp=0001", err); end
        total++; if (mem[10] !== 32'h2222_2222 || mem[11] !== 32'h0000_100b || mem[12] !== 32'h0000_100c) begin
            bad++; $display("FAIL oob_mem got=%h %h %h exp=22222222 0000100b 0000100c", mem[10], mem[11], mem[12]); end
    endtask

    task automatic test_backpressure();
        logic [3:0][31:0] held; logic [3:0] held_err; int t;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_mask = 4'b1111;
        req_addr = {6'd7, 6'd6, 6'd5, 6'd4}; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_op = 2'b01; req_addr = {6'd20, 6'd20, 6'd20, 6'd20};
        req_wdata = {4{32'hDEAD_BEEF}};
        t = 0;
        while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid got=%b exp=1", rsp_valid); end
        held = rsp_data_a; held_err = rsp_err;
        total++; if (held !== {32'h0000_1007, 32'h0000_1006, 32'h0000_1005, 32'h0000_1004}) begin bad++; $display("FAIL bp_data got=%h", held); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_data_a !== held || rsp_err !== held_err || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h %b v=%b r=%b", c, rsp_data_a, rsp_err, rsp_valid, req_ready);
            end
        end
        total++; if (mem[20] !== 32'h0000_1014) begin bad++; $display("FAIL bp_ignored got=%h exp=00001014", mem[20]); end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b%b exp=10", req_ready, busy); end
        total++; if (ops_done !== 16'd5) begin bad++; $display("FAIL bp_ops got=%0d exp=5", ops_done); end
    endtask

    task automatic test_reset_exec_reserved();
        logic [3:0][31:0] ra, rb; logic [3:0] err, wen; int wc, lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_mask = 4'b1111;
        req_addr = {6'd8, 6'd7, 6'd6, 6'd5}; req_wdata = {4{32'hFFFF_0000}};
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (mem[5] !== 32'h0000_1005 || mem[6] !== 32'h0000_1006 || mem[7] !== 32'h0000_1007 || mem[8] !== 32'h0000_1008) begin
            bad++; $display("FAIL rst_exec_mem got=%h %h %h %h", mem[5], mem[6], mem[7], mem[8]); end
        total++; if (ops_done !== 16'd0 || busy !== 1'b0 || mem_write_en !== 4'd0) begin bad++; $display("FAIL rst_exec_state ops=%0d busy=%b wen=%b", ops_done, busy, mem_write_en); end
        @(negedge clk); rst_n = 1'b1;
        run_op(2'b11, 4'b0110, {6'd3, 6'd2, 6'd1, 6'd0}, {4{32'h5555_5555}}, ra, rb, err, wen, wc, lat);
        total++; if (err !== 4'b0110) begin bad++; $display("FAIL rsvd_err got=%b exp=0110", err); end
        total++; if (wc !== 0 || ra !== 128'd0 || rb !== 128'd0) begin bad++; $display("FAIL rsvd_effect wcyc=%0d a=%h b=%h", wc, ra, rb); end
        total++; if (ops_done !== 16'd1) begin bad++; $display("FAIL rsvd_ops got=%0d exp=1", ops_done); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'h0000_1000 + 32'(k);
        req_valid = 1'b0; req_op = 2'b00; req_mask = 4'd0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_store_load();
        test_load_pair();
        test_oob_store();
        test_backpressure();
        test_reset_exec_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
